alu_cmd_sequencer: RTL and testbench

- Upstream issue stage for the 4-bit ALU.
- Buffers operand/opcode commands from the front-end (switch/button logic or a host) in a small FIFO.
- Presents one command at a time to the ALU, holding operands and selector stable for a fixed settle window, then captures the 5-bit ALU result.
- Returns each result to the consumer over a valid/ready handshake, tagged with its opcode.

---
 rtl/alu_cmd_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: issue stage in front of the 4-bit ALU.
//
// Commands {op, b, a} are queued in a DEPTH-entry FIFO. One command at a time is
// driven onto alu_a/alu_b/alu_sel and held for HOLD_CYCLES cycles. The 5-bit ALU
// result is then captured and returned to the consumer over a valid/ready
// handshake, tagged with the opcode that produced it.
//
// Optional feature (macro ALU_DIV0_GUARD_EN): a popped divide/modulo command
// (op 3'b011 or 3'b100) with b == 0 is not issued. It returns res_data = 5'h1F
// and raises err_div0 for the duration of that result.
//
// Ports:
//   clk, rst_n               clock (rising edge), synchronous active-low reset
//   cmd_valid/cmd_ready      command push handshake; cmd_a, cmd_b, cmd_op payload
//   alu_a, alu_b, alu_sel    operands and selector driven to the ALU
//   alu_result               ALU result, sampled at the end of the hold window
//   res_valid/res_ready      result handshake; res_data, res_op payload
//   err_div0                 divide-by-zero flag (ALU_DIV0_GUARD_EN only)
//   busy                     FIFO non-empty or a command in flight

module alu_cmd_sequencer #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    input  logic [2:0] cmd_op,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_sel,
    input  logic [4:0] alu_result,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [4:0] res_data,
    output logic [2:0] res_op,
`ifdef ALU_DIV0_GUARD_EN
    output logic       err_div0,
`endif
    output logic       busy
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [PtrW:0]   FullCount = (PtrW + 1)'(DEPTH);
    localparam logic [CntW-1:0] HoldLoad  = CntW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StResp
    } state_e;

    // FIFO storage and pointers
    logic [10:0]     mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]   count_q, count_d;

    // Sequencer state
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      alu_a_q, alu_a_d;
    logic [3:0]      alu_b_q, alu_b_d;
    logic [2:0]      alu_sel_q, alu_sel_d;
    logic            res_valid_q, res_valid_d;
    logic [4:0]      res_data_q, res_data_d;
    logic [2:0]      res_op_q, res_op_d;

    logic       push, pop;
    logic [3:0] head_a, head_b;
    logic [2:0] head_op;
    logic       div0_hit;

    assign cmd_ready = (count_q != FullCount);
    assign push      = cmd_valid && cmd_ready;
    // Popping is tied to the FSM taking a command, so it only happens in IDLE.
    assign pop       = (state_q == StIdle) && (count_q != '0);

    assign head_a  = mem_q[rd_ptr_q][3:0];
    assign head_b  = mem_q[rd_ptr_q][7:4];
    assign head_op = mem_q[rd_ptr_q][10:8];

`ifdef ALU_DIV0_GUARD_EN
    assign div0_hit = ((head_op == 3'b011) || (head_op == 3'b100)) && (head_b == 4'd0);
`else
    assign div0_hit = 1'b0;
`endif

    // FIFO pointer/occupancy next state; pointers wrap naturally (DEPTH is 2^n).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Sequencer next state
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_op_d    = res_op_q;
        unique case (state_q)
            StIdle: begin
                if (pop) begin
                    if (div0_hit) begin
                        // Short-circuit: ALU operands keep their previous values.
                        res_data_d  = 5'h1F;
                        res_op_d    = head_op;
                        res_valid_d = 1'b1;
                        state_d     = StResp;
                    end else begin
                        alu_a_d   = head_a;
                        alu_b_d   = head_b;
                        alu_sel_d = head_op;
                        cnt_d     = HoldLoad;
                        state_d   = StIssue;
                    end
                end
            end
            StIssue: begin
                if (cnt_q == '0) begin
                    res_data_d  = alu_result;
                    res_op_d    = alu_sel_q;
                    res_valid_d = 1'b1;
                    state_d     = StResp;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StResp: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= StIdle;
            cnt_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_op_q    <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_op_q    <= res_op_d;
        end
    end

    // Storage is not reset: entries are only read when occupancy says they are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cmd_op, cmd_b, cmd_a};
        end
    end

`ifdef ALU_DIV0_GUARD_EN
    logic err_div0_q, err_div0_d;

    always_comb begin
        err_div0_d = err_div0_q;
        if (pop && div0_hit) begin
            err_div0_d = 1'b1;
        end else if (res_valid_q && res_ready) begin
            err_div0_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_div0_q <= 1'b0;
        end else begin
            err_div0_q <= err_div0_d;
        end
    end

    assign err_div0 = err_div0_q;
`endif

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_op    = res_op_q;
    assign busy      = (count_q != '0) || (state_q != StIdle);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer (DEPTH=4, HOLD_CYCLES=2) with a small
// behavioural ALU. Build with +define+ALU_DIV0_GUARD_EN to cover the guard.

module tb_alu_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_a, cmd_b;
    logic [2:0] cmd_op;
    logic [3:0] alu_a, alu_b;
    logic [2:0] alu_sel;
    logic [4:0] alu_result;
    logic       res_valid;
    logic       res_ready;
    logic [4:0] res_data;
    logic [2:0] res_op;
    logic       busy;
`ifdef ALU_DIV0_GUARD_EN
    logic       err_div0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(
        .DEPTH       (4),
        .HOLD_CYCLES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_op     (cmd_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_result (alu_result),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_op     (res_op),
`ifdef ALU_DIV0_GUARD_EN
        .err_div0   (err_div0),
`endif
        .busy       (busy)
    );

    // Bench ALU: add, sub, div, mod (0 on b==0), logic ops.
    always_comb begin
        alu_result = 5'd0;
        case (alu_sel)
            3'b000: alu_result = {1'b0, alu_a & alu_b};
            3'b001: alu_result = {1'b0, alu_a} + {1'b0, alu_b};
            3'b010: alu_result = {1'b0, alu_a} - {1'b0, alu_b};
            3'b011: alu_result = (alu_b == 4'd0) ? 5'd0 : {1'b0, alu_a / alu_b};
            3'b100: alu_result = (alu_b == 4'd0) ? 5'd0 : {1'b0, alu_a % alu_b};
            3'b101: alu_result = {1'b0, alu_a | alu_b};
            3'b110: alu_result = {1'b0, alu_a ^ alu_b};
            default: alu_result = {1'b0, ~alu_a};
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic set_cmd(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        cmd_a  = a;
        cmd_b  = b;
        cmd_op = op;
    endtask

    initial begin
        logic [3:0] q_a   [4];
        logic [3:0] q_b   [4];
        logic [2:0] q_op  [4];
        logic [4:0] exp_d [4];
        int         idx;
        int         seen;
        int         n;

        q_a = '{4'd1, 4'd7, 4'd12, 4'd6};
        q_b = '{4'd2, 4'd8, 4'd10, 4'd3};
        q_op = '{3'b001, 3'b010, 3'b110, 3'b011};
        exp_d = '{5'd3, 5'h1F, 5'd6, 5'd2};

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        set_cmd(4'd0, 4'd0, 3'd0);
        tick();
        tick();

        // Reset state
        check("rst_cmd_ready", 8'(cmd_ready), 8'd1);
        check("rst_busy", 8'(busy), 8'd0);
        check("rst_res_valid", 8'(res_valid), 8'd0);
        check("rst_res_data", 8'(res_data), 8'd0);
        check("rst_alu_a", 8'(alu_a), 8'd0);
        check("rst_alu_sel", 8'(alu_sel), 8'd0);
        rst_n = 1'b1;
        tick();

        // Single add, latency and busy
        res_ready = 1'b1;
        set_cmd(4'd5, 4'd3, 3'b001);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("lat_t0_valid", 8'(res_valid), 8'd0);
        check("lat_t0_busy", 8'(busy), 8'd1);
        tick();
        check("lat_t1_alu_a", 8'(alu_a), 8'd5);
        check("lat_t1_alu_b", 8'(alu_b), 8'd3);
        check("lat_t1_alu_sel", 8'(alu_sel), 8'd1);
        check("lat_t1_valid", 8'(res_valid), 8'd0);
        tick();
        check("lat_t2_valid", 8'(res_valid), 8'd0);
        tick();
        check("lat_t3_valid", 8'(res_valid), 8'd1);
        check("lat_t3_data", 8'(res_data), 8'd8);
        check("lat_t3_op", 8'(res_op), 8'd1);
        tick();
        check("lat_t4_valid", 8'(res_valid), 8'd0);
        check("lat_t4_busy", 8'(busy), 8'd0);

        // Subtract with stalled consumer
        res_ready = 1'b0;
        set_cmd(4'd3, 4'd5, 3'b010);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        tick();
        check("sub_valid", 8'(res_valid), 8'd1);
        check("sub_data", 8'(res_data), 8'h1E);
        check("sub_op", 8'(res_op), 8'd2);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_valid", 8'(res_valid), 8'd1);
            check("stall_data", 8'(res_data), 8'h1E);
            check("stall_op", 8'(res_op), 8'd2);
        end

        // Fill the FIFO behind the stalled result
        for (int i = 0; i < 4; i++) begin
            set_cmd(q_a[i], q_b[i], q_op[i]);
            cmd_valid = 1'b1;
            tick();
            if (i == 2) begin
                check("fill3_ready", 8'(cmd_ready), 8'd1);
            end
        end
        check("full_ready", 8'(cmd_ready), 8'd0);
        check("full_busy", 8'(busy), 8'd1);
        set_cmd(4'd1, 4'd1, 3'b001);
        tick();
        check("full_drop_ready", 8'(cmd_ready), 8'd0);
        check("full_hold_data", 8'(res_data), 8'h1E);

        // Release the stalled result; a push offered while still full is dropped.
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        tick();
        check("hs_valid", 8'(res_valid), 8'd0);
        check("hs_ready_still_full", 8'(cmd_ready), 8'd0);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("pop_ready", 8'(cmd_ready), 8'd1);
        check("pop_alu_a", 8'(alu_a), 8'd1);
        check("pop_alu_sel", 8'(alu_sel), 8'd1);

        // Drain: exactly the four queued results, in order
        idx = 0;
        for (int i = 0; i < 30; i++) begin
            if (res_valid) begin
                if (idx < 4) begin
                    check("drain_data", 8'(res_data), 8'(exp_d[idx]));
                    check("drain_op", 8'(res_op), 8'(q_op[idx]));
                end
                idx++;
            end
            tick();
        end
        check("drain_count", 8'(idx), 8'd4);
        check("drain_busy", 8'(busy), 8'd0);
        check("drain_ready", 8'(cmd_ready), 8'd1);

        // Reset during ISSUE with two entries queued
        for (int i = 0; i < 3; i++) begin
            set_cmd(4'(i + 2), 4'(i + 2), 3'b001);
            cmd_valid = 1'b1;
            tick();
        end
        cmd_valid = 1'b0;
        check("issue_alu_a", 8'(alu_a), 8'd2);
        check("issue_busy", 8'(busy), 8'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_alu_a", 8'(alu_a), 8'd0);
        check("mid_rst_alu_b", 8'(alu_b), 8'd0);
        check("mid_rst_alu_sel", 8'(alu_sel), 8'd0);
        check("mid_rst_valid", 8'(res_valid), 8'd0);
        check("mid_rst_data", 8'(res_data), 8'd0);
        check("mid_rst_op", 8'(res_op), 8'd0);
        check("mid_rst_ready", 8'(cmd_ready), 8'd1);
        check("mid_rst_busy", 8'(busy), 8'd0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (res_valid) seen++;
        end
        check("mid_rst_no_result", 8'(seen), 8'd0);
        check("mid_rst_busy_after", 8'(busy), 8'd0);

        // Divide by zero, preceded by an add to set alu_sel
        set_cmd(4'd5, 4'd3, 3'b001);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        n = 0;
        while (!res_valid && n < 8) begin
            tick();
            n++;
        end
        check("pre_div_valid", 8'(res_valid), 8'd1);
        tick();
        set_cmd(4'd9, 4'd0, 3'b011);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        n = 0;
        while (!res_valid && n < 8) begin
            tick();
            n++;
        end
        check("div0_valid", 8'(res_valid), 8'd1);
        check("div0_op", 8'(res_op), 8'd3);
`ifdef ALU_DIV0_GUARD_EN
        check("div0_latency", 8'(n), 8'd1);
        check("div0_data", 8'(res_data), 8'h1F);
        check("div0_err", 8'(err_div0), 8'd1);
        check("div0_alu_sel_kept", 8'(alu_sel), 8'd1);
        check("div0_alu_a_kept", 8'(alu_a), 8'd5);
`else
        check("div0_latency", 8'(n), 8'd3);
        check("div0_data", 8'(res_data), 8'd0);
        check("div0_alu_sel", 8'(alu_sel), 8'd3);
        check("div0_alu_a", 8'(alu_a), 8'd9);
`endif
        tick();
        check("div0_hs_valid", 8'(res_valid), 8'd0);
        check("div0_hs_busy", 8'(busy), 8'd0);
`ifdef ALU_DIV0_GUARD_EN
        check("div0_hs_err", 8'(err_div0), 8'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
